// File: rtl/phase_sync.sv
// Phase-aligned start-up sequencer for an ultrasonic transducer array.
// Releases each channel's PWM counter reset at its own delay within one carrier period.
module phase_sync #(
    parameter int N_CH   = 8,
    parameter int PERIOD = 1250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_ch,
    input  logic [10:0]        cfg_delay,
    input  logic [9:0]         cfg_duty,
    input  logic               start,
    input  logic               stop,
    output logic [N_CH-1:0]    ch_rst,
    output logic [N_CH*10-1:0] ch_compare,
    output logic               state_busy,
    output logic               done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam logic [10:0] DLY_MAX  = 11'(PERIOD - 1);
    localparam logic [9:0]  DUTY_MAX = (PERIOD > 1023) ? 10'h3FF : 10'(PERIOD);

    logic [1:0]  state;
    logic [10:0] timer;

    logic [10:0] shd_delay [N_CH];
    logic [9:0]  shd_duty  [N_CH];
    logic [10:0] act_delay [N_CH];
    logic [9:0]  act_duty  [N_CH];

    logic [31:0] ch_idx;
    logic        cfg_hit;
    logic        start_go;
    logic        align_end;
    logic [10:0] wr_delay;
    logic [9:0]  wr_duty;

    assign cfg_ready  = (state != ALIGN);
    assign state_busy = (state == ALIGN);

    assign ch_idx    = 32'(cfg_ch);
    assign cfg_hit   = cfg_valid && cfg_ready && (ch_idx < 32'(N_CH));
    assign wr_delay  = (cfg_delay > DLY_MAX) ? DLY_MAX : cfg_delay;
    assign wr_duty   = (32'(cfg_duty) > 32'(PERIOD)) ? DUTY_MAX : cfg_duty;
    assign start_go  = start && !stop && (state != ALIGN);
    assign align_end = (state == ALIGN) && (timer == DLY_MAX);

    for (genvar g = 0; g < N_CH; g++) begin : g_cmp
        assign ch_compare[10*g +: 10] = act_duty[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                shd_delay[i] <= '0;
                shd_duty[i]  <= '0;
            end
        end else if (cfg_hit) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_idx == 32'(i)) begin
                    shd_delay[i] <= wr_delay;
                    shd_duty[i]  <= wr_duty;
                end
            end
        end
    end

    // Active pairs load from the pre-edge shadow, so a same-cycle write waits for the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                act_delay[i] <= '0;
                act_duty[i]  <= '0;
            end
        end else if (start_go) begin
            for (int i = 0; i < N_CH; i++) begin
                act_delay[i] <= shd_delay[i];
                act_duty[i]  <= shd_duty[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            ch_rst <= '1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                ch_rst <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        ch_rst <= '1;
                        if (start) begin
                            state <= ALIGN;
                            timer <= '0;
                        end
                    end
                    ALIGN: begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (timer == act_delay[i]) ch_rst[i] <= 1'b0;
                        end
                        if (align_end) begin
                            state  <= RUN;
                            done   <= 1'b1;
                            ch_rst <= '0;
                        end else begin
                            timer <= timer + 11'd1;
                        end
                    end
                    RUN: begin
                        if (start) begin
                            state  <= ALIGN;
                            timer  <= '0;
                            ch_rst <= '1;
                        end else begin
                            ch_rst <= '0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        ch_rst <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sync.sv
// Directed self-checking bench for phase_sync.
// Drives and samples on the falling clock edge.
module tb_phase_sync;

    localparam int N_CH   = 8;
    localparam int PERIOD = 1250;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [2:0]         cfg_ch = '0;
    logic [10:0]        cfg_delay = '0;
    logic [9:0]         cfg_duty = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [N_CH-1:0]    ch_rst;
    logic [N_CH*10-1:0] ch_compare;
    logic               state_busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_sync #(.N_CH(N_CH), .PERIOD(PERIOD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_duty   (cfg_duty),
        .start      (start),
        .stop       (stop),
        .ch_rst     (ch_rst),
        .ch_compare (ch_compare),
        .state_busy (state_busy),
        .done       (done)
    );

    task automatic cfg_write(input logic [2:0] ch, input logic [10:0] d,
                             input logic [9:0] u);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_delay = d;
        cfg_duty  = u;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (ch_rst !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_ch_rst: got %h expected ff", ch_rst);
        end
        n_checks++;
        if (ch_compare !== '0) begin
            n_fail++;
            $display("FAIL reset_compare: got %h expected 0", ch_compare);
        end
        n_checks++;
        if (state_busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b ready=%b expected 0 0 1",
                     state_busy, done, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int busy_cnt = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (state_busy) busy_cnt++;
            end
            n_checks++;
            if (busy_cnt !== 0) begin
                n_fail++;
                $display("FAIL idle_hold: busy cycles %0d expected 0", busy_cnt);
            end
        end
    endtask

    task automatic test_align();
        int f0 = -1, f1 = -1, f7 = -1, dk = -1, dn = 0, rdy = 0;
        cfg_write(3'd0, 11'd0, 10'd11);
        cfg_write(3'd1, 11'd100, 10'd22);
        cfg_write(3'd7, 11'd1249, 10'd33);
        pulse_start();
        n_checks++;
        if (ch_rst !== 8'hFF || state_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL align_entry: ch_rst=%h busy=%b expected ff 1", ch_rst, state_busy);
        end
        for (int k = 1; k <= 1260; k++) begin
            @(negedge clk);
            if (f0 < 0 && !ch_rst[0]) f0 = k;
            if (f1 < 0 && !ch_rst[1]) f1 = k;
            if (f7 < 0 && !ch_rst[7]) f7 = k;
            if (done) begin
                dn++;
                if (dk < 0) dk = k;
            end
            if (state_busy && cfg_ready) rdy++;
        end
        n_checks++;
        if (f0 !== 1) begin
            n_fail++;
            $display("FAIL ch0_fall: cycle %0d expected 1", f0);
        end
        n_checks++;
        if (f1 - f0 !== 100) begin
            n_fail++;
            $display("FAIL ch1_fall: offset %0d expected 100", f1 - f0);
        end
        n_checks++;
        if (f7 - f0 !== 1249) begin
            n_fail++;
            $display("FAIL ch7_fall: offset %0d expected 1249", f7 - f0);
        end
        n_checks++;
        if (dk !== 1250 || dn !== 1) begin
            n_fail++;
            $display("FAIL done_pulse: at %0d count %0d expected 1250 1", dk, dn);
        end
        n_checks++;
        if (ch_rst !== 8'h00 || state_busy !== 1'b0 || rdy !== 0) begin
            n_fail++;
            $display("FAIL run_state: ch_rst=%h busy=%b rdy=%0d expected 00 0 0",
                     ch_rst, state_busy, rdy);
        end
        n_checks++;
        if (ch_compare[70 +: 10] !== 10'd33 || ch_compare[10 +: 10] !== 10'd22) begin
            n_fail++;
            $display("FAIL align_compare: ch7=%0d ch1=%0d expected 33 22",
                     ch_compare[70 +: 10], ch_compare[10 +: 10]);
        end
    endtask

    task automatic test_clamp();
        cfg_write(3'd3, 11'd2000, 10'd1023);
        n_checks++;
        if (ch_compare[30 +: 10] !== 10'd0) begin
            n_fail++;
            $display("FAIL clamp_pre: ch3=%0d expected 0", ch_compare[30 +: 10]);
        end
        pulse_start();
        n_checks++;
        if (ch_rst !== 8'hFF) begin
            n_fail++;
            $display("FAIL restart_rst: got %h expected ff", ch_rst);
        end
        n_checks++;
        if (ch_compare[30 +: 10] !== 10'd1023) begin
            n_fail++;
            $display("FAIL clamp_duty: ch3=%0d expected 1023", ch_compare[30 +: 10]);
        end
        n_checks++;
        if (dut.act_delay[3] !== 11'd1249) begin
            n_fail++;
            $display("FAIL clamp_delay: got %0d expected 1249", dut.act_delay[3]);
        end
        repeat (1260) @(negedge clk);
    endtask

    task automatic test_shadow_run();
        int rdy = 0, busy_cnt = 0;
        cfg_write(3'd2, 11'd0, 10'd500);
        repeat (5) @(negedge clk);
        n_checks++;
        if (ch_compare[20 +: 10] !== 10'd0) begin
            n_fail++;
            $display("FAIL shadow_hold: ch2=%0d expected 0", ch_compare[20 +: 10]);
        end
        pulse_start();
        n_checks++;
        if (ch_compare[20 +: 10] !== 10'd500) begin
            n_fail++;
            $display("FAIL shadow_load: ch2=%0d expected 500", ch_compare[20 +: 10]);
        end
        for (int k = 1; k <= 1260; k++) begin
            @(negedge clk);
            if (state_busy) busy_cnt++;
            if (state_busy && cfg_ready) rdy++;
        end
        n_checks++;
        if (rdy !== 0 || busy_cnt !== 1249) begin
            n_fail++;
            $display("FAIL align_ready: rdy=%0d busy=%0d expected 0 1249", rdy, busy_cnt);
        end
    endtask

    task automatic test_start_stop();
        int dn = 0, busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (ch_rst !== 8'hFF || state_busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_prio: ch_rst=%h busy=%b ready=%b expected ff 0 1",
                     ch_rst, state_busy, cfg_ready);
        end
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (state_busy) busy_cnt++;
        end
        n_checks++;
        if (dn !== 0 || busy_cnt !== 0 || ch_rst !== 8'hFF) begin
            n_fail++;
            $display("FAIL stop_idle: done=%0d busy=%0d ch_rst=%h expected 0 0 ff",
                     dn, busy_cnt, ch_rst);
        end
    endtask

    task automatic test_same_cycle();
        cfg_write(3'd5, 11'd0, 10'd10);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd5;
        cfg_delay = 11'd0;
        cfg_duty  = 10'd20;
        start     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (ch_compare[50 +: 10] !== 10'd10) begin
            n_fail++;
            $display("FAIL same_cycle_old: ch5=%0d expected 10", ch_compare[50 +: 10]);
        end
        repeat (1260) @(negedge clk);
        pulse_start();
        n_checks++;
        if (ch_compare[50 +: 10] !== 10'd20) begin
            n_fail++;
            $display("FAIL same_cycle_new: ch5=%0d expected 20", ch_compare[50 +: 10]);
        end
    endtask

    task automatic test_async_reset();
        int busy_cnt = 0, dn = 0;
        repeat (600) @(negedge clk);
        n_checks++;
        if (dut.timer !== 11'd600) begin
            n_fail++;
            $display("FAIL timer_600: got %0d expected 600", dut.timer);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ch_rst !== 8'hFF || ch_compare !== '0) begin
            n_fail++;
            $display("FAIL async_rst_out: ch_rst=%h cmp=%h expected ff 0", ch_rst, ch_compare);
        end
        n_checks++;
        if (state_busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_flags: busy=%b done=%b ready=%b expected 0 0 1",
                     state_busy, done, cfg_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            if (state_busy) busy_cnt++;
            if (done) dn++;
        end
        n_checks++;
        if (busy_cnt !== 0 || dn !== 0 || ch_rst !== 8'hFF) begin
            n_fail++;
            $display("FAIL post_rst_idle: busy=%0d done=%0d ch_rst=%h expected 0 0 ff",
                     busy_cnt, dn, ch_rst);
        end
        pulse_start();
        n_checks++;
        if (state_busy !== 1'b1 || ch_compare !== '0) begin
            n_fail++;
            $display("FAIL post_rst_start: busy=%b cmp=%h expected 1 0", state_busy, ch_compare);
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_clamp();
        test_shadow_run();
        test_start_stop();
        test_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
